// File: rtl/pfpu_fmul_arb.sv
// -----------------------------------------------------------------------------
// pfpu_fmul_arb
//
// Shares one pipelined FP multiplier between four requesters (PFPU ALU lanes
// and the DMA pre-scaler). At most one operation is issued per cycle, chosen
// round-robin. A requester id travels down a tag pipeline in lock-step with the
// multiplier, so every result can be steered back to whoever issued it.
//
// Handshakes:
//   req/gnt   - a requester raises req[k] with its operands on a_bus/b_bus and
//               holds both stable until gnt[k] is high in the same cycle; the
//               operation transfers in exactly that cycle. gnt is combinational
//               and at most one-hot.
//   res_valid - push only, no back-pressure: res is valid for the single cycle
//               in which the owner's res_valid bit is high.
//
// Ports:
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   req[3:0]            per-requester request level
//   a_bus, b_bus        operands, requester k on bits [32k+31:32k]
//   gnt[3:0]            one-hot grant (same cycle as req)
//   flush               one-cycle pulse, abort everything in flight
//   m_a, m_b            registered multiplier operands
//   m_valid_i           registered multiplier issue strobe
//   m_rst               registered one-cycle synchronous reset to the multiplier
//   m_r, m_valid_o      multiplier result and result strobe
//   res                 registered result data
//   res_valid[3:0]      one-hot result strobe naming the owner
//   busy                any operation in flight or being returned
//   err                 sticky: multiplier strobe disagreed with the tag pipeline
//
// The multiplier must be reset by the same reset source as this block; an
// asynchronous reset discards all in-flight state here.
// -----------------------------------------------------------------------------
module pfpu_fmul_arb #(
    parameter int LATENCY = 6,  // multiplier valid_i -> valid_o latency
    parameter int MAX_OUT = 4   // in-flight ops per requester, 1..7
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic [3:0]   req,
    input  logic [127:0] a_bus,
    input  logic [127:0] b_bus,
    output logic [3:0]   gnt,
    input  logic         flush,
    output logic [31:0]  m_a,
    output logic [31:0]  m_b,
    output logic         m_valid_i,
    output logic         m_rst,
    input  logic [31:0]  m_r,
    input  logic         m_valid_o,
    output logic [31:0]  res,
    output logic [3:0]   res_valid,
    output logic         busy,
    output logic         err
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0] ptr;                 // round-robin start point
    logic       arb_en;              // low while in reset, keeps gnt at zero
    logic [2:0] cnt [4];             // in-flight ops per requester
    logic [1:0] issue_id;            // id travelling with m_valid_i (stage 0)
    logic [LATENCY:1] tag_v;         // tag pipeline valids, tail = LATENCY
    logic [1:0] tag_id [1:LATENCY];  // tag pipeline ids
    logic [1:0] fw;                  // flush-window cycles still to run

    // ------------------------------------------------------------------------
    // Flush window bookkeeping
    //   Cycle F carries the flush pulse; fw is 2 in F+1 and 1 in F+2.
    //   err is frozen for F..F+2 while the multiplier drains its stale
    //   strobes; result capture is blocked for the returns computed in F and
    //   F+1 (i.e. res_valid stays low at edges F+1 and F+2).
    // ------------------------------------------------------------------------
    logic in_window;
    logic res_block;

    assign in_window = flush | (fw != 2'd0);
    assign res_block = flush | (fw == 2'd2);

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic [3:0] elig;
    logic [1:0] gnt_id;
    logic       gnt_vld;

    always_comb begin
        logic [1:0] idx;
        logic       found;
        elig   = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < 4; i++) begin
            elig[i] = req[i] && (cnt[i] < MAX_CNT);
        end
        // Scan ptr, ptr+1, ... with natural 2-bit wrap.
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && elig[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
        gnt_vld = found && !flush && arb_en;
    end

    always_comb begin
        gnt = '0;
        if (gnt_vld) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ptr    <= 2'd0;
            arb_en <= 1'b0;
        end else begin
            arb_en <= 1'b1;
            // ptr is deliberately untouched by flush.
            if (gnt_vld) begin
                ptr <= gnt_id + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Issue stage
    // gnt_vld is already low in a flush cycle, so the issue strobe drops at
    // F+1 without further qualification. Operands hold when nothing issues.
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_a       <= '0;
            m_b       <= '0;
            m_valid_i <= 1'b0;
            m_rst     <= 1'b0;
            issue_id  <= '0;
        end else begin
            m_rst     <= flush;
            m_valid_i <= gnt_vld;
            if (gnt_vld) begin
                m_a      <= a_bus[{gnt_id, 5'd0} +: 32];
                m_b      <= b_bus[{gnt_id, 5'd0} +: 32];
                issue_id <= gnt_id;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Tag pipeline
    // Stage 0 is {m_valid_i, issue_id}. The multiplier samples that stage at
    // the next edge, so LATENCY further stages put the tail in the same cycle
    // as the matching m_valid_o.
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tag_v <= '0;
            for (int j = 1; j <= LATENCY; j++) begin
                tag_id[j] <= '0;
            end
        end else begin
            tag_v[1]  <= m_valid_i & ~flush;
            tag_id[1] <= issue_id;
            for (int j = 2; j <= LATENCY; j++) begin
                tag_v[j]  <= tag_v[j-1] & ~flush;
                tag_id[j] <= tag_id[j-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Return path and error detection
    // ------------------------------------------------------------------------
    logic       tail_v;
    logic [1:0] tail_id;
    logic       ret_ok;
    logic [3:0] ret_vec;

    assign tail_v  = tag_v[LATENCY];
    assign tail_id = tag_id[LATENCY];
    assign ret_ok  = m_valid_o && tail_v && !res_block;
    assign ret_vec = ret_ok ? (4'b0001 << tail_id) : 4'b0000;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            res       <= '0;
            res_valid <= '0;
            err       <= 1'b0;
            fw        <= 2'd0;
        end else begin
            res_valid <= ret_vec;
            if (ret_ok) begin
                res <= m_r;
            end
            // A strobe without a tag (or a tag without a strobe) means the
            // multiplier and this block have lost step; latch it.
            if (!in_window && (m_valid_o != tail_v)) begin
                err <= 1'b1;
            end
            if (flush) begin
                fw <= 2'd2;
            end else if (fw != 2'd0) begin
                fw <= fw - 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outstanding-op counters
    // The decrement lands on the same edge that raises res_valid, so in the
    // cycle a result is presented its owner is already eligible again.
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < 4; k++) begin
                cnt[k] <= 3'd0;
            end
        end else if (flush) begin
            for (int k = 0; k < 4; k++) begin
                cnt[k] <= 3'd0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                cnt[k] <= cnt[k] + {2'b00, gnt[k]} - {2'b00, ret_vec[k]};
            end
        end
    end

    // Eligibility keeps the counters inside 0..MAX_OUT.
    always @(posedge sys_clk) begin
        if (sys_rst_n && !flush) begin
            for (int k = 0; k < 4; k++) begin
                assert (!(gnt[k] && !ret_vec[k] && cnt[k] == 3'd7))
                    else $error("cnt[%0d] overflow", k);
                assert (!(ret_vec[k] && !gnt[k] && cnt[k] == 3'd0))
                    else $error("cnt[%0d] underflow", k);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Activity
    // ------------------------------------------------------------------------
    assign busy = m_valid_i | (|tag_v) | (|res_valid);

endmodule

// File: tb/tb_pfpu_fmul_arb.sv
// -----------------------------------------------------------------------------
// tb_pfpu_fmul_arb
//
// Drives pfpu_fmul_arb against a behavioural 6-stage FP multiplier and checks
// every cycle against a transaction-level model: each grant becomes an
// expected result due LATENCY+2 cycles later; a requester's in-flight count
// is simply how many of its expected results are still queued.
// -----------------------------------------------------------------------------
module tb_pfpu_fmul_arb;

  localparam int LATENCY = 6;
  localparam int MAX_OUT = 4;
  localparam int W       = 66;  // {due[31:0], id[1:0], value[31:0]}

  logic         sys_clk;
  logic         sys_rst_n;
  logic [3:0]   req;
  logic [127:0] a_bus;
  logic [127:0] b_bus;
  logic [3:0]   gnt;
  logic         flush;
  logic [31:0]  m_a;
  logic [31:0]  m_b;
  logic         m_valid_i;
  logic         m_rst;
  logic [31:0]  m_r;
  logic         m_valid_o;
  logic [31:0]  res;
  logic [3:0]   res_valid;
  logic         busy;
  logic         err;
  logic         inj;

  pfpu_fmul_arb #(.LATENCY(LATENCY), .MAX_OUT(MAX_OUT)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .gnt       (gnt),
    .flush     (flush),
    .m_a       (m_a),
    .m_b       (m_b),
    .m_valid_i (m_valid_i),
    .m_rst     (m_rst),
    .m_r       (m_r),
    .m_valid_o (m_valid_o),
    .res       (res),
    .res_valid (res_valid),
    .busy      (busy),
    .err       (err)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Behavioural FP multiply (normal operands, truncating)
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  function automatic logic [31:0] rand_op();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  function automatic logic [127:0] rand_bus();
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = rand_op();
    return r;
  endfunction

  // Multiplier stand-in: LATENCY register stages, synchronous m_rst.
  logic        mv [1:LATENCY];
  logic [31:0] mr [1:LATENCY];

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n || m_rst) begin
      for (int j = 1; j <= LATENCY; j++) begin
        mv[j] <= 1'b0;
        mr[j] <= '0;
      end
    end else begin
      mv[1] <= m_valid_i;
      mr[1] <= fp_mul(m_a, m_b);
      for (int j = 2; j <= LATENCY; j++) begin
        mv[j] <= mv[j-1];
        mr[j] <= mr[j-1];
      end
    end
  end

  assign m_valid_o = mv[LATENCY] | inj;
  assign m_r       = mr[LATENCY];

  // ---------------------------------------------------------------------------
  // Scoreboard / model state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           cyc;
  int           n_checks;
  int           n_errors;
  int           ptr_m;
  logic [3:0]   prev_g;
  logic         prev_f;
  logic [31:0]  prev_a;
  logic [31:0]  prev_b;
  logic [3:0]   g_exp;
  logic         exp_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pending(input int k);
    int c = 0;
    for (int n = 0; n < exp_q.size(); n++) begin
      if (exp_q[n][33:32] == 2'(k)) c++;
    end
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one cycle of stimulus plus all per-cycle comparisons
  // ---------------------------------------------------------------------------
  task automatic step(input logic [3:0] r, input logic f, input logic [127:0] a,
                      input logic [127:0] b, input logic i);
    logic [W-1:0] e;
    int           gk;
    @(posedge sys_clk);
    cyc++;
    #1;
    req   = r;
    flush = f;
    a_bus = a;
    b_bus = b;
    inj   = i;
    @(negedge sys_clk);

    check_eq("busy", 32'(busy), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0 && exp_q[0][65:34] == 32'(cyc)) begin
      e = exp_q.pop_front();
      check_eq("res_valid", 32'(res_valid), 32'(4'b0001 << e[33:32]));
      check_eq("res", res, e[31:0]);
    end else begin
      check_eq("res_valid", 32'(res_valid), 32'd0);
    end
    check_eq("m_valid_i", 32'(m_valid_i), 32'(|prev_g));
    if (|prev_g) begin
      check_eq("m_a", m_a, prev_a);
      check_eq("m_b", m_b, prev_b);
    end
    check_eq("m_rst", 32'(m_rst), 32'(prev_f));
    check_eq("err", 32'(err), 32'(exp_err));

    g_exp = 4'b0000;
    gk    = 0;
    if (!f) begin
      for (int n = 0; n < 4; n++) begin
        int k;
        k = (ptr_m + n) % 4;
        if (g_exp == 4'b0000 && r[k] && pending(k) < MAX_OUT) begin
          g_exp[k] = 1'b1;
          gk       = k;
        end
      end
    end
    check_eq("gnt", 32'(gnt), 32'(g_exp));

    prev_g = g_exp;
    prev_f = f;
    if (g_exp != 4'b0000) begin
      ptr_m  = (gk + 1) % 4;
      prev_a = a[32*gk +: 32];
      prev_b = b[32*gk +: 32];
      exp_q.push_back({32'(cyc + LATENCY + 2), 2'(gk), fp_mul(prev_a, prev_b)});
    end
    if (f) exp_q.delete();
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(4'b0000, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gnt"}, 32'(gnt), 32'd0);
    check_eq({tag, "_m_valid_i"}, 32'(m_valid_i), 32'd0);
    check_eq({tag, "_m_rst"}, 32'(m_rst), 32'd0);
    check_eq({tag, "_m_a"}, m_a, 32'd0);
    check_eq({tag, "_m_b"}, m_b, 32'd0);
    check_eq({tag, "_res"}, res, 32'd0);
    check_eq({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    ptr_m   = 0;
    prev_g  = 4'b0000;
    prev_f  = 1'b0;
    exp_err = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [3:0]   hold;
    logic [3:0]   seen;
    logic [127:0] ab;
    logic [127:0] bb;
    int           n_g;

    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    inj       = 1'b0;
    flush     = 1'b0;
    a_bus     = rand_bus();
    b_bus     = rand_bus();
    req       = 4'b1111;
    sys_rst_n = 1'b0;
    model_reset();

    // Reset state, with requests pending to show gnt is held off.
    repeat (3) @(posedge sys_clk);
    #1;
    check_all_zero("reset");
    @(negedge sys_clk);
    req       = 4'b0000;
    sys_rst_n = 1'b1;

    // Round-robin: all four held for 8 cycles from ptr=0.
    for (int c = 0; c < 8; c++) begin
      step(4'b1111, 1'b0, rand_bus(), rand_bus(), 1'b0);
      check_eq("rr_seq", 32'(gnt), 32'(4'b0001 << (c % 4)));
    end
    idle(12);

    // Single op: 2.0 * 3.0 from requester 0.
    step(4'b0001, 1'b0, {96'd0, 32'h40000000}, {96'd0, 32'h40400000}, 1'b0);
    idle(8);
    check_eq("single_res", res, 32'h40C00000);
    check_eq("single_valid", 32'(res_valid), 32'h1);
    idle(1);
    check_eq("single_idle", 32'(busy), 32'd0);

    // Outstanding limit: requester 2 alone, held continuously.
    n_g = 0;
    for (int c = 0; c < 12; c++) begin
      step(4'b0100, 1'b0, rand_bus(), rand_bus(), 1'b0);
      if (c < 8 && gnt != 4'b0000) n_g++;
      if (c >= 4 && c < 8) check_eq("limit_stall", 32'(gnt), 32'd0);
      if (c == 8) check_eq("limit_resume", 32'(gnt), 32'h4);
    end
    check_eq("limit_grants", 32'(n_g), 32'd4);
    idle(12);

    // Flush: three ops, flush at T+3, new op from requester 3 at T+4.
    hold = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      step(hold, 1'b0, rand_bus(), rand_bus(), 1'b0);
      hold &= ~g_exp;
    end
    step(4'b0000, 1'b1, rand_bus(), rand_bus(), 1'b0);
    check_eq("flush_gnt", 32'(gnt), 32'd0);
    step(4'b1000, 1'b0, rand_bus(), rand_bus(), 1'b0);
    check_eq("flush_mrst_hi", 32'(m_rst), 32'd1);
    check_eq("flush_busy", 32'(busy), 32'd0);
    seen = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      step(4'b0000, 1'b0, rand_bus(), rand_bus(), 1'b0);
      if (c == 0) check_eq("flush_mrst_lo", 32'(m_rst), 32'd0);
      seen |= res_valid;
    end
    check_eq("flush_returns", 32'(seen), 32'h8);
    check_eq("flush_err", 32'(err), 32'd0);

    // Spurious multiplier strobe with an empty pipeline.
    step(4'b0000, 1'b0, '0, '0, 1'b1);
    exp_err = 1'b1;
    idle(4);
    check_eq("err_sticky", 32'(err), 32'd1);

    // Async reset between edges with traffic in flight.
    for (int c = 0; c < 3; c++) step(4'b1111, 1'b0, rand_bus(), rand_bus(), 1'b0);
    @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("async");
    model_reset();
    @(negedge sys_clk);
    #2;
    req       = 4'b0000;
    sys_rst_n = 1'b1;
    idle(2);

    // Randomised traffic with occasional flushes.
    hold = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (!hold[k] && $urandom_range(0, 9) < 4) hold[k] = 1'b1;
      end
      ab = rand_bus();
      bb = rand_bus();
      step(hold, ($urandom_range(0, 39) == 0), ab, bb, 1'b0);
      hold &= ~g_exp;
    end
    idle(12);
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pfpu_fmul_arb.md
Name: pfpu_fmul_arb

Overview:
- Round-robin arbiter sharing one 6-stage pipelined FP multiplier between 4 requesters (PFPU ALU lanes / DMA pre-scaler).
- Issues at most one operation per cycle and tracks a requester tag alongside each in-flight operation.
- Routes each result back to its issuer, enforces a per-requester outstanding-op limit, and sequences a pipeline flush via the multiplier's synchronous reset.

Parameters:
- LATENCY, 6: multiplier valid_i-to-valid_o latency in cycles; sets tag pipeline depth.
- MAX_OUT, 4: maximum in-flight ops per requester, range 1..7.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- req  in  4  per-requester request; level, held until granted.
- a_bus  in  128  operand A; requester k uses bits [32k+31:32k].
- b_bus  in  128  operand B; same packing as a_bus.
- gnt  out  4  one-hot grant, combinational, same cycle as req.
- flush  in  1  one-cycle pulse; abort all in-flight ops.
- m_a  out  32  multiplier operand A (registered).
- m_b  out  32  multiplier operand B (registered).
- m_valid_i  out  1  multiplier issue strobe (registered).
- m_rst  out  1  multiplier synchronous reset (registered).
- m_r  in  32  multiplier result.
- m_valid_o  in  1  multiplier result strobe.
- res  out  32  result data (registered).
- res_valid  out  4  one-hot result strobe, identifies the owner.
- busy  out  1  high while any op is in flight.
- err  out  1  sticky: strobe/tag mismatch detected.

Behaviour:
- Reset (sys_rst_n=0, async): gnt=0, m_valid_i=0, m_rst=0, m_a=m_b=0, res=0, res_valid=0, busy=0, err=0. Priority pointer=0, counters=0, tag pipeline valids=0.
- Eligibility: requester k is eligible iff req[k]=1 and cnt[k]<MAX_OUT.
- Arbitration:
  - Grant the first eligible requester scanning ptr, ptr+1, ... mod 4.
  - gnt is one-hot or zero; it is forced to zero in a flush cycle.
  - On a grant to k, ptr <= k+1 mod 4 at the next edge; otherwise ptr holds.
- Issue (grant at cycle T):
  - At edge T+1: m_a/m_b <= operands of k, m_valid_i <= 1, tag stage 0 <= {valid=1, id=k}.
  - With no grant: m_valid_i <= 0; m_a/m_b hold.
- Tag pipeline:
  - LATENCY entries of {valid, id[1:0]}, shifting every cycle.
  - The tail entry is aligned with m_valid_o.
- Return:
  - m_valid_o and tail.valid both 1: res <= m_r, res_valid <= one-hot(tail.id) at the next edge. Total latency is grant cycle T -> res_valid at T+LATENCY+2 (8 by default).
  - m_valid_o != tail.valid outside the flush window: err <= 1 (sticky until reset); res_valid stays 0 for that cycle.
  - res_valid is a single-cycle pulse per result.
- Counters cnt[k] (3 bits):
  - +1 on grant to k; -1 on res_valid[k]; both in the same cycle -> unchanged.
  - Saturation is impossible by eligibility; assert in simulation.
- Flush:
  - Flush cycle F: gnt=0.
  - Edge F+1: m_rst <= 1 for exactly one cycle; all tag valids, counters and m_valid_i cleared; ptr preserved.
  - res_valid is suppressed at edges F+1 and F+2.
  - The flush window is cycles F..F+2; err is not updated inside it.
  - Arbitration resumes at F+1.
  - Flush while m_rst=1: window extended, m_rst re-pulsed.
- busy = any tag valid | m_valid_i | (res_valid != 0).
- Async reset mid-operation: all in-flight state lost; the multiplier must be reset by the same reset source.

Test Plan:
- Single op: req=0001, a0=0x40000000 (2.0), b0=0x40400000 (3.0) -> gnt=0001 at T; res=0x40C00000, res_valid=0001 at T+8; cnt[0] returns to 0.
- Round-robin: req=1111 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,...; results return in issue order with matching res_valid one-hot, one per cycle.
- Outstanding limit: MAX_OUT=4, only req[2] asserted continuously -> 4 grants in cycles 0-3, gnt=0 in cycles 4-7, next grant in the same cycle res_valid[2] first pulses (cycle 8); throughput 4 ops per 8 cycles.
- Flush: issue 3 ops, flush at T+3 -> m_rst high exactly at cycle T+4, no res_valid for those ops, cnt all 0, busy=0 by T+5, err=0; a new op issued at T+4 returns correctly.
- Error: inject spurious m_valid_o with empty pipeline -> err=1 next cycle and stays 1; res_valid=0.
- Async reset asserted mid-stream between clock edges -> all outputs 0 immediately, without waiting for a clock edge.
